complex_mag_stream_udiv_47ns_6ns_47_seq: RTL and testbench

- Sequential unsigned divider; the inverse of the 41x6 unsigned multiply stage in the complex_mag_stream datapath.
- Divides a 47-bit unsigned dividend (product-domain value) by a 6-bit unsigned divisor. Returns quotient and remainder.
- Restoring shift-subtract, one quotient bit per cycle, valid/ready handshakes on input and output.
- Global ce freezes the block, matching the datapath's other arithmetic units.

---
 rtl/complex_mag_stream_udiv_pkg.sv | 27 ++
 rtl/complex_mag_stream_udiv_step.sv | 31 +++
 rtl/complex_mag_stream_udiv_47ns_6ns_47_seq.sv | 154 +++++++++++++++
 tb/tb_complex_mag_stream_udiv_47ns_6ns_47_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_mag_stream_udiv_pkg.sv
//------------------------------------------------------------------------------
// complex_mag_stream_udiv_pkg
// Shared types, default widths and iteration helpers for the sequential divider.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package complex_mag_stream_udiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int c_DIN0_WIDTH_DEF = 47;
  localparam int c_DIN1_WIDTH_DEF = 6;
  localparam int c_CNT_WIDTH      = $clog2(c_DIN0_WIDTH_DEF);

  // Two quotient bits per iteration, rounding up for odd dividend widths.
  function automatic int radix4_iters(input int width);
    return (width + 1) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/complex_mag_stream_udiv_step.sv
//------------------------------------------------------------------------------
// complex_mag_stream_udiv_step
// One combinational restoring shift-subtract step.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module complex_mag_stream_udiv_step #(
  parameter int DW = 6
) (
  input  logic [DW:0]   prem,
  input  logic          din,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   prem_nxt,
  output logic          q
);

  logic [DW+1:0] w_shifted;
  logic [DW+2:0] w_diff;

  always_comb begin
    w_shifted = {prem, din};
    w_diff    = {1'b0, w_shifted} - {3'b000, divisor};
    // A clear borrow bit means the trial subtract did not go negative.
    q         = ~w_diff[DW+2];
    prem_nxt  = q ? w_diff[DW:0] : w_shifted[DW:0];
  end

endmodule

`default_nettype wire

// File: rtl/complex_mag_stream_udiv_47ns_6ns_47_seq.sv
//------------------------------------------------------------------------------
// complex_mag_stream_udiv_47ns_6ns_47_seq
// Sequential restoring unsigned divider with valid/ready handshakes and ce.
// Option macro: COMPLEX_MAG_STREAM_UDIV_RADIX4_EN (two quotient bits per cycle).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module complex_mag_stream_udiv_47ns_6ns_47_seq
  import complex_mag_stream_udiv_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = c_DIN0_WIDTH_DEF,
  parameter int din1_WIDTH = c_DIN1_WIDTH_DEF,
  parameter int dout_WIDTH = c_DIN0_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

`ifdef COMPLEX_MAG_STREAM_UDIV_RADIX4_EN
  localparam int c_SW       = 2 * radix4_iters(din0_WIDTH);
  localparam int c_CNT_INIT = radix4_iters(din0_WIDTH) - 1;
`else
  localparam int c_SW       = din0_WIDTH;
  localparam int c_CNT_INIT = din0_WIDTH - 1;
`endif
  localparam int c_CNT_W = $clog2(din0_WIDTH);

  if (dout_WIDTH != din0_WIDTH || ID < 0) begin : g_bad_cfg
    $error("dout_WIDTH must equal din0_WIDTH");
  end

  state_t                r_state;
  logic [c_SW-1:0]       r_sr;
  logic [din1_WIDTH:0]   r_prem;
  logic [din1_WIDTH-1:0] r_div;
  logic [din1_WIDTH-1:0] r_dz_rem;
  logic                  r_zero;
  logic [c_CNT_W-1:0]    r_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [dout_WIDTH-1:0] r_quot;
  logic [din1_WIDTH-1:0] r_rem;
  logic                  r_dbz;

  logic [din1_WIDTH:0]   w_prem_a;
  logic                  w_q_a;
  logic [din1_WIDTH:0]   w_prem_nxt;
  logic [c_SW-1:0]       w_sr_nxt;

  complex_mag_stream_udiv_step #(.DW(din1_WIDTH)) u_step_a (
    .prem     (r_prem),
    .din      (r_sr[c_SW-1]),
    .divisor  (r_div),
    .prem_nxt (w_prem_a),
    .q        (w_q_a)
  );

`ifdef COMPLEX_MAG_STREAM_UDIV_RADIX4_EN
  logic [din1_WIDTH:0] w_prem_b;
  logic                w_q_b;

  complex_mag_stream_udiv_step #(.DW(din1_WIDTH)) u_step_b (
    .prem     (w_prem_a),
    .din      (r_sr[c_SW-2]),
    .divisor  (r_div),
    .prem_nxt (w_prem_b),
    .q        (w_q_b)
  );

  assign w_prem_nxt = w_prem_b;
  assign w_sr_nxt   = {r_sr[c_SW-3:0], w_q_a, w_q_b};
`else
  assign w_prem_nxt = w_prem_a;
  assign w_sr_nxt   = {r_sr[c_SW-2:0], w_q_a};
`endif

  // Quotient bits enter at the LSB as dividend bits leave at the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_prem      <= '0;
      r_div       <= '0;
      r_dz_rem    <= '0;
      r_zero      <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
    end else if (ce) begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sr       <= c_SW'(din0);
            r_prem     <= '0;
            r_div      <= din1;
            r_dz_rem   <= din0[din1_WIDTH-1:0];
            r_zero     <= (din1 == '0);
            r_cnt      <= c_CNT_W'(c_CNT_INIT);
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_sr   <= w_sr_nxt;
          r_prem <= w_prem_nxt;
          r_cnt  <= r_cnt - c_CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle registers the result; afterwards wait for the consumer.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_quot      <= r_zero ? '1 : r_sr[dout_WIDTH-1:0];
            r_rem       <= r_zero ? r_dz_rem : r_prem[din1_WIDTH-1:0];
            r_dbz       <= r_zero;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quot        = r_quot;
  assign rem         = r_rem;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_complex_mag_stream_udiv_47ns_6ns_47_seq.sv
//------------------------------------------------------------------------------
// tb_complex_mag_stream_udiv_47ns_6ns_47_seq
// Directed bench with a quotient/remainder reference model and per-cycle monitor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_complex_mag_stream_udiv_47ns_6ns_47_seq;

`ifdef COMPLEX_MAG_STREAM_UDIV_RADIX4_EN
  localparam int c_EXP_LAT = 25;
`else
  localparam int c_EXP_LAT = 48;
`endif

  typedef struct {
    logic [46:0] q;
    logic [5:0]  r;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [46:0] din0 = '0;
  logic [5:0]  din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [46:0] quot;
  logic [5:0]  rem;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic ce_rand = 1'b0;

  complex_mag_stream_udiv_47ns_6ns_47_seq dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din0        (din0),
    .din1        (din1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [46:0] a, input logic [5:0] b);
    res_t r;
    if (b == 6'd0) begin
      r.q  = '1;
      r.r  = a[5:0];
      r.dz = 1'b1;
    end else begin
      r.q  = a / b;
      r.r  = 6'(a % b);
      r.dz = 1'b0;
    end
    return r;
  endfunction

  // Monitor: scoreboard, latency, in_ready model and hold-stability checks.
  res_t        exp_q[$];
  logic        model_busy = 1'b0;
  logic        tracking = 1'b0;
  int          lat = 0;
  logic        prev_hold = 1'b0;
  logic [46:0] prev_quot;
  logic [5:0]  prev_rem;
  logic        prev_dz;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_busy = 1'b0;
      tracking   = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      res_t e;
      chk("in_ready_model", {63'd0, in_ready}, {63'd0, !model_busy});
      if (prev_hold) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_quot", {17'd0, quot}, {17'd0, prev_quot});
        chk("hold_rem", {58'd0, rem}, {58'd0, prev_rem});
        chk("hold_dz", {63'd0, div_by_zero}, {63'd0, prev_dz});
      end
      if (tracking && out_valid) begin
        chk("latency", 64'(lat), 64'(c_EXP_LAT));
        tracking = 1'b0;
      end
      if (in_valid && in_ready && ce) begin
        exp_q.push_back(model(din0, din1));
        model_busy = 1'b1;
        tracking   = 1'b1;
        lat        = 0;
      end else if (tracking && ce) begin
        lat++;
      end
      if (out_valid && out_ready && ce) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_quot", {17'd0, quot}, {17'd0, e.q});
          chk("sb_rem", {58'd0, rem}, {58'd0, e.r});
          chk("sb_dz", {63'd0, div_by_zero}, {63'd0, e.dz});
        end
        model_busy = 1'b0;
      end
      prev_hold = out_valid && !(out_ready && ce);
      prev_quot = quot;
      prev_rem  = rem;
      prev_dz   = div_by_zero;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic start_div(input logic [46:0] a, input logic [5:0] b);
    int n = 0;
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready && ce) && n < 500);
    chk("accept", {63'd0, in_ready && ce}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [46:0] eq, input logic [5:0] er, input logic edz);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 500);
    chk("result_valid", {63'd0, out_valid}, 64'd1);
    chk("lit_quot", {17'd0, quot}, {17'd0, eq});
    chk("lit_rem", {58'd0, rem}, {58'd0, er});
    chk("lit_dz", {63'd0, div_by_zero}, {63'd0, edz});
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_quot", {17'd0, quot}, 64'd0);
    chk("rst_rem", {58'd0, rem}, 64'd0);
    chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
    @(posedge clk);
    #1;

    start_div(47'd37000, 6'd37);
    wait_result(47'd1000, 6'd0, 1'b0);

    start_div(47'h7FFF_FFFF_FFFF, 6'd63);
    wait_result(47'h0208_2082_0820, 6'd31, 1'b0);

    start_div(47'd123, 6'd0);
    wait_result('1, 6'd59, 1'b1);

    start_div(47'd5, 6'd9);
    wait_result(47'd0, 6'd5, 1'b0);

    start_div(47'h7FFF_FFFF_FFFF, 6'd1);
    wait_result(47'h7FFF_FFFF_FFFF, 6'd0, 1'b0);

    // Random ce with ignored in_valid pulses while busy.
    ce_rand = 1'b1;
    fork
      begin
        start_div(47'd100, 6'd7);
        wait_result(47'd14, 6'd2, 1'b0);
        ce_rand = 1'b0;
      end
      begin
        while (ce_rand) begin
          @(posedge clk);
          #1;
          ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        ce = 1'b1;
      end
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (in_ready && n < 500);
        repeat (5) begin
          @(posedge clk);
          #1;
          din0 = 47'd77;
          din1 = 6'd1;
          in_valid = 1'b1;
          @(posedge clk);
          #1;
          in_valid = 1'b0;
        end
      end
    join
    @(posedge clk);
    #1;

    // Backpressure then back-to-back division.
    out_ready = 1'b0;
    start_div(47'd1234, 6'd10);
    wait_result(47'd123, 6'd4, 1'b0);
    repeat (20) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("release_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    start_div(47'd46, 6'd5);
    wait_result(47'd9, 6'd1, 1'b0);

    // Reset in the middle of a division.
    start_div(47'd1000, 6'd3);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_quot", {17'd0, quot}, 64'd0);
    @(posedge clk);
    #1;
    start_div(47'd9, 6'd3);
    wait_result(47'd3, 6'd0, 1'b0);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
